// File: rtl/countdown_timer.sv
// Hour/minute/second countdown timer with a prescaled one-second tick and one-cycle expiry pulse.
// Optional feature: define COUNTDOWN_AUTO_RELOAD_EN to reload the last loaded value on expiry and keep running.
module countdown_timer #(
    parameter int unsigned TICK_DIV = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_in,
    input  logic       start_in,
    input  logic       pause_in,
    input  logic [5:0] sec_in,
    input  logic [5:0] min_in,
    input  logic [5:0] hour_in,
    output logic [5:0] sec_out,
    output logic [5:0] min_out,
    output logic [5:0] hour_out,
    output logic       running_out,
    output logic       done_out,
    output logic       zero_out
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    localparam int unsigned   PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

    state_t        state, nxt_state;
    logic [PW-1:0] presc, nxt_presc;
    logic [5:0]    nxt_sec, nxt_min, nxt_hour;
    logic          nxt_done;

    logic [5:0]    ld_sec, ld_min, ld_hour;
    logic          ld_zero;
    logic [5:0]    dec_sec, dec_min, dec_hour;
    logic          dec_zero;
    logic          tick;

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    logic [5:0] rl_sec, rl_min, rl_hour;
    logic [5:0] nxt_rl_sec, nxt_rl_min, nxt_rl_hour;
`endif

    // Saturated load values and the borrow-chain decrement of the current count
    always_comb begin
        ld_sec   = (sec_in  > 6'd59) ? 6'd59 : sec_in;
        ld_min   = (min_in  > 6'd59) ? 6'd59 : min_in;
        ld_hour  = (hour_in > 6'd23) ? 6'd23 : hour_in;
        ld_zero  = (ld_sec == '0) && (ld_min == '0) && (ld_hour == '0);
        tick     = (presc == PRESC_MAX);
        dec_sec  = sec_out;
        dec_min  = min_out;
        dec_hour = hour_out;
        if (sec_out != '0) begin
            dec_sec = sec_out - 6'd1;
        end else if (min_out != '0) begin
            dec_min = min_out - 6'd1;
            dec_sec = 6'd59;
        end else if (hour_out != '0) begin
            dec_hour = hour_out - 6'd1;
            dec_min  = 6'd59;
            dec_sec  = 6'd59;
        end
        dec_zero = (sec_out == 6'd1) && (min_out == '0) && (hour_out == '0);
    end

    // State and counter register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state       <= IDLE;
            presc       <= '0;
            sec_out     <= '0;
            min_out     <= '0;
            hour_out    <= '0;
            running_out <= 1'b0;
            done_out    <= 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            rl_sec      <= '0;
            rl_min      <= '0;
            rl_hour     <= '0;
`endif
        end else begin
            state       <= nxt_state;
            presc       <= nxt_presc;
            sec_out     <= nxt_sec;
            min_out     <= nxt_min;
            hour_out    <= nxt_hour;
            running_out <= (nxt_state == RUN);
            done_out    <= nxt_done;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            rl_sec      <= nxt_rl_sec;
            rl_min      <= nxt_rl_min;
            rl_hour     <= nxt_rl_hour;
`endif
        end
    end

    // Next-state logic; load_in outranks pause_in, which outranks start_in
    always_comb begin
        nxt_state = state;
        nxt_presc = presc;
        nxt_sec   = sec_out;
        nxt_min   = min_out;
        nxt_hour  = hour_out;
        nxt_done  = 1'b0;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        nxt_rl_sec  = rl_sec;
        nxt_rl_min  = rl_min;
        nxt_rl_hour = rl_hour;
`endif
        if (load_in) begin
            nxt_sec   = ld_sec;
            nxt_min   = ld_min;
            nxt_hour  = ld_hour;
            nxt_presc = '0;
            nxt_state = (state == RUN && !ld_zero) ? RUN : IDLE;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
            nxt_rl_sec  = ld_sec;
            nxt_rl_min  = ld_min;
            nxt_rl_hour = ld_hour;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start_in && !zero_out) begin
                        nxt_state = RUN;
                        nxt_presc = '0;
                    end
                end
                PAUSE: begin
                    if (start_in && !zero_out) begin
                        nxt_state = RUN;
                    end
                end
                RUN: begin
                    if (pause_in) begin
                        nxt_state = PAUSE;
                    end else if (tick) begin
                        nxt_presc = '0;
                        if (dec_zero) begin
                            nxt_done = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
                            nxt_sec  = rl_sec;
                            nxt_min  = rl_min;
                            nxt_hour = rl_hour;
`else
                            nxt_sec   = '0;
                            nxt_min   = '0;
                            nxt_hour  = '0;
                            nxt_state = DONE;
`endif
                        end else begin
                            nxt_sec  = dec_sec;
                            nxt_min  = dec_min;
                            nxt_hour = dec_hour;
                        end
                    end else begin
                        nxt_presc = presc + PW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Output logic
    always_comb begin
        zero_out = (sec_out == '0) && (min_out == '0) && (hour_out == '0);
    end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed scoreboard bench for countdown_timer, with TICK_DIV=1 and TICK_DIV=4 instances on shared inputs.
module tb_countdown_timer;

    logic       clk = 1'b0;
    logic       rst, load_in, start_in, pause_in;
    logic [5:0] sec_in, min_in, hour_in;

    logic [5:0] s1, m1, h1, s4, m4, h4;
    logic       run1, done1, zero1, run4, done4, zero4;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string       tag;
        bit          sel;
        logic [20:0] v;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    countdown_timer #(.TICK_DIV(1)) u_dut1 (
        .clk(clk), .rst(rst), .load_in(load_in), .start_in(start_in), .pause_in(pause_in),
        .sec_in(sec_in), .min_in(min_in), .hour_in(hour_in),
        .sec_out(s1), .min_out(m1), .hour_out(h1),
        .running_out(run1), .done_out(done1), .zero_out(zero1)
    );

    countdown_timer #(.TICK_DIV(4)) u_dut4 (
        .clk(clk), .rst(rst), .load_in(load_in), .start_in(start_in), .pause_in(pause_in),
        .sec_in(sec_in), .min_in(min_in), .hour_in(hour_in),
        .sec_out(s4), .min_out(m4), .hour_out(h4),
        .running_out(run4), .done_out(done4), .zero_out(zero4)
    );

    task automatic cmd(input bit r, input bit ld, input bit st, input bit ps,
                       input logic [5:0] h, input logic [5:0] m, input logic [5:0] s);
        rst = r; load_in = ld; start_in = st; pause_in = ps;
        hour_in = h; min_in = m; sec_in = s;
    endtask

    // Queue the expected outputs after the coming clock edge
    task automatic expect_out(input bit sel, input string tag,
                              input logic [5:0] h, input logic [5:0] m, input logic [5:0] s,
                              input bit run, input bit done);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.v   = {s, m, h, run, done, (s == 6'd0 && m == 6'd0 && h == 6'd0)};
        sb.push_back(e);
    endtask

    task automatic tick_check();
        exp_t        e;
        logic [20:0] obs;
        @(posedge clk);
        #1;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = e.sel ? {s4, m4, h4, run4, done4, zero4} : {s1, m1, h1, run1, done1, zero1};
            tests++;
            assert (obs === e.v) else begin
                fails++;
                $error("FAIL %s: observed s/m/h/run/done/zero=%0d/%0d/%0d/%b/%b/%b expected %0d/%0d/%0d/%b/%b/%b",
                       e.tag, obs[20:15], obs[14:9], obs[8:3], obs[2], obs[1], obs[0],
                       e.v[20:15], e.v[14:9], e.v[8:3], e.v[2], e.v[1], e.v[0]);
            end
        end
    endtask

    initial begin
        cmd(0, 0, 0, 0, 0, 0, 0);
        expect_out(0, "reset_d1", 0, 0, 0, 0, 0);
        expect_out(1, "reset_d4", 0, 0, 0, 0, 0);
        tick_check();
        tick_check();

        cmd(1, 1, 0, 0, 0, 0, 3);
        expect_out(0, "load_003", 0, 0, 3, 0, 0);
        tick_check();
        cmd(1, 0, 1, 0, 0, 0, 0);
        expect_out(0, "start_003", 0, 0, 3, 1, 0);
        tick_check();
        cmd(1, 0, 0, 0, 0, 0, 0);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        expect_out(0, "count_2", 0, 0, 2, 1, 0);
        tick_check();
        expect_out(0, "count_1", 0, 0, 1, 1, 0);
        tick_check();
        expect_out(0, "reload_3", 0, 0, 3, 1, 1);
        tick_check();
        cmd(1, 1, 0, 0, 0, 0, 2);
        expect_out(0, "load_run_002", 0, 0, 2, 1, 0);
        tick_check();
        cmd(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            expect_out(0, "reload_cycle_1", 0, 0, 1, 1, 0);
            tick_check();
            expect_out(0, "reload_cycle_2", 0, 0, 2, 1, 1);
            tick_check();
        end
        cmd(1, 1, 0, 0, 31, 60, 63);
        expect_out(0, "saturate", 23, 59, 59, 1, 0);
        tick_check();
        cmd(1, 1, 0, 0, 0, 0, 0);
        expect_out(0, "load_zero_run", 0, 0, 0, 0, 0);
        tick_check();
        cmd(1, 0, 1, 0, 0, 0, 0);
        expect_out(0, "start_zero", 0, 0, 0, 0, 0);
        tick_check();
`else
        expect_out(0, "count_2", 0, 0, 2, 1, 0);
        tick_check();
        expect_out(0, "count_1", 0, 0, 1, 1, 0);
        tick_check();
        expect_out(0, "expire", 0, 0, 0, 0, 1);
        tick_check();
        expect_out(0, "done_hold", 0, 0, 0, 0, 0);
        tick_check();
        cmd(1, 0, 1, 0, 0, 0, 0);
        expect_out(0, "start_in_done", 0, 0, 0, 0, 0);
        tick_check();

        cmd(1, 1, 0, 0, 1, 0, 0);
        expect_out(0, "load_100", 1, 0, 0, 0, 0);
        tick_check();
        cmd(1, 0, 1, 0, 0, 0, 0);
        expect_out(0, "start_100", 1, 0, 0, 1, 0);
        tick_check();
        cmd(1, 0, 0, 0, 0, 0, 0);
        expect_out(0, "borrow_hour", 0, 59, 59, 1, 0);
        tick_check();
        cmd(1, 1, 0, 0, 0, 1, 0);
        expect_out(0, "load_run_010", 0, 1, 0, 1, 0);
        tick_check();
        cmd(1, 0, 0, 0, 0, 0, 0);
        expect_out(0, "borrow_min", 0, 0, 59, 1, 0);
        tick_check();

        cmd(1, 1, 0, 0, 0, 0, 3);
        expect_out(0, "load_run_003", 0, 0, 3, 1, 0);
        tick_check();
        cmd(1, 0, 0, 0, 0, 0, 0);
        expect_out(0, "run_at_2", 0, 0, 2, 1, 0);
        tick_check();
        cmd(1, 1, 0, 0, 0, 0, 5);
        expect_out(0, "load_mid_005", 0, 0, 5, 1, 0);
        tick_check();
        cmd(1, 0, 0, 0, 0, 0, 0);
        expect_out(0, "continue_4", 0, 0, 4, 1, 0);
        tick_check();

        cmd(1, 1, 0, 0, 31, 60, 63);
        expect_out(0, "saturate", 23, 59, 59, 1, 0);
        tick_check();
        cmd(1, 1, 0, 0, 0, 0, 0);
        expect_out(0, "load_zero_run", 0, 0, 0, 0, 0);
        tick_check();
        cmd(1, 0, 1, 0, 0, 0, 0);
        expect_out(0, "start_zero", 0, 0, 0, 0, 0);
        tick_check();

        cmd(1, 1, 0, 0, 0, 0, 2);
        expect_out(0, "load_002", 0, 0, 2, 0, 0);
        tick_check();
        cmd(1, 0, 1, 0, 0, 0, 0);
        expect_out(0, "start_002", 0, 0, 2, 1, 0);
        tick_check();
        cmd(1, 0, 0, 0, 0, 0, 0);
        expect_out(0, "run_at_1", 0, 0, 1, 1, 0);
        tick_check();
        cmd(0, 0, 0, 0, 0, 0, 0);
        expect_out(0, "reset_mid_run", 0, 0, 0, 0, 0);
        expect_out(1, "reset_mid_d4", 0, 0, 0, 0, 0);
        tick_check();
        cmd(1, 0, 0, 0, 0, 0, 0);
        expect_out(0, "reset_no_done", 0, 0, 0, 0, 0);
        tick_check();

        // TICK_DIV=4 instance: pause with prescaler at 2, resume keeps the phase
        cmd(1, 1, 0, 0, 0, 0, 2);
        expect_out(1, "d4_load", 0, 0, 2, 0, 0);
        tick_check();
        cmd(1, 0, 1, 0, 0, 0, 0);
        expect_out(1, "d4_start", 0, 0, 2, 1, 0);
        tick_check();
        cmd(1, 0, 0, 0, 0, 0, 0);
        expect_out(1, "d4_presc1", 0, 0, 2, 1, 0);
        tick_check();
        expect_out(1, "d4_presc2", 0, 0, 2, 1, 0);
        tick_check();
        cmd(1, 0, 0, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            expect_out(1, "d4_paused", 0, 0, 2, 0, 0);
            tick_check();
        end
        cmd(1, 0, 1, 0, 0, 0, 0);
        expect_out(1, "d4_resume", 0, 0, 2, 1, 0);
        tick_check();
        cmd(1, 0, 0, 0, 0, 0, 0);
        expect_out(1, "d4_resume_wait", 0, 0, 2, 1, 0);
        tick_check();
        expect_out(1, "d4_first_dec", 0, 0, 1, 1, 0);
        tick_check();
        cmd(1, 0, 1, 1, 0, 0, 0);
        expect_out(1, "d4_pause_and_start", 0, 0, 1, 0, 0);
        tick_check();
        cmd(1, 0, 1, 0, 0, 0, 0);
        expect_out(1, "d4_resume2", 0, 0, 1, 1, 0);
        tick_check();
        cmd(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            expect_out(1, "d4_wait_tick", 0, 0, 1, 1, 0);
            tick_check();
        end
        expect_out(1, "d4_expire", 0, 0, 0, 0, 1);
        tick_check();
        expect_out(1, "d4_done_hold", 0, 0, 0, 0, 0);
        tick_check();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Hour/minute/second countdown timer: the down-counting counterpart of the existing up-counting clock FSM chain.
- Loads hh:mm:ss, decrements one second per tick and flags expiry.
- Outputs use the same 6-bit BCD-free binary encoding, so they can drive the same display/compare logic as the clock block.
- Sits beside the clock chain in the top level, sharing clk, rst and the load/time input buses.

Parameters:
- TICK_DIV, 1, clk cycles per one-second tick; must be >= 1. At 1, every clk is one second, matching the clock FSMs.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous active-low reset, sampled on rising clk
- load_in  input  1  capture sec_in/min_in/hour_in into the counters
- start_in  input  1  begin or resume countdown
- pause_in  input  1  hold countdown
- sec_in  input  6  seconds load value
- min_in  input  6  minutes load value
- hour_in  input  6  hours load value
- sec_out  output  6  remaining seconds, 0..59
- min_out  output  6  remaining minutes, 0..59
- hour_out  output  6  remaining hours, 0..23
- running_out  output  1  high while state is RUN
- done_out  output  1  one-cycle expiry pulse
- zero_out  output  1  combinational; high when all counters are 0

Behaviour:
- Reset: rst==0 at a clk edge sets
  - state=IDLE, sec/min/hour_out=0, prescaler=0;
  - running_out=0, done_out=0;
  - zero_out reads 1.
- Reset mid-RUN aborts immediately. No pulse is generated.
- Priority: rst > load_in > pause_in > start_in.
- States:
  - IDLE, RUN, PAUSE, DONE; encoding is free.
  - running_out is registered, equal to (state==RUN).
- Load (any state):
  - Counters take inputs, saturated: sec>59 gives 59, min>59 gives 59, hour>23 gives 23.
  - Prescaler clears.
  - IDLE, PAUSE or DONE go to IDLE. RUN stays RUN and continues from the new value.
  - Loading 0:0:0 in RUN forces IDLE with no done_out.
- start_in:
  - IDLE or PAUSE with nonzero count: go to RUN. Prescaler clears only on IDLE->RUN; PAUSE->RUN keeps it.
  - Zero count, or state DONE: start is ignored.
- pause_in in RUN: go to PAUSE. Prescaler and counters are frozen. pause_in outside RUN is ignored.
- Prescaler in RUN:
  - Counts 0..TICK_DIV-1.
  - Tick occurs on the edge where prescaler==TICK_DIV-1, after which it wraps to 0.
  - With TICK_DIV=1, every RUN edge is a tick.
- Decrement on tick, borrow chain:
  - sec>0: sec-1;
  - else min>0: min-1, sec=59;
  - else hour>0: hour-1, min=59, sec=59.
- Expiry:
  - The tick that makes the count 0:0:0 also moves state to DONE.
  - done_out is high for exactly the following cycle, registered alongside the counter update.
- DONE: holds 0:0:0 until load_in, which goes to IDLE.
- Latency, TICK_DIV=1:
  - load at edge 0, start at edge 1 (RUN visible after it);
  - decrements at edges 2, 3, …;
  - for N seconds, done_out is high after edge N+1.
- Counters never underflow and never exceed 59/59/23.

Optional Feature:
- Macro: COUNTDOWN_AUTO_RELOAD_EN.
- Defined:
  - Each load_in also stores the saturated value in reload registers.
  - The tick that would reach 0:0:0 instead loads the reload registers.
  - done_out still pulses for one cycle; state remains RUN.
  - Period = loaded_seconds*TICK_DIV cycles. A reload value of 0:0:0 cannot run, because start is ignored.
  - Load in RUN updates both the counters and the reload registers.
- Undefined: no reload registers; behaviour as above (RUN to DONE).

Test Plan:
- Reset/saturation: TICK_DIV=1, rst low 2 cycles, then load 0:0:3 and start -> after reset all outputs 0 and zero_out=1. Then sec_out goes 3,2,1,0 on consecutive edges; done_out high 1 cycle with sec_out=0; state DONE; running_out=0.
- Borrow chain: load 1:0:0, start -> next tick gives 0:59:59. Then load 0:1:0 -> tick gives 0:0:59.
- Saturation: load sec=63, min=60, hour=31 -> outputs 59:59:23.
- Pause/resume: TICK_DIV=4, load 0:0:2, start, pause at prescaler=2 for 10 cycles, then start -> first decrement lands 2 cycles after resume; no counter change while paused. Assert pause_in and start_in together in RUN -> PAUSE.
- Ignored starts: start with 0:0:0 loaded -> stays IDLE, running_out=0. Start in DONE -> no change. Load mid-RUN 0:0:5 at count 0:0:2 -> continues from 5, no done_out.
- Reset mid-run: rst low while at 0:0:1 in RUN -> next cycle 0:0:0, IDLE, done_out never asserted.
- With COUNTDOWN_AUTO_RELOAD_EN: TICK_DIV=1, load 0:0:2, start -> done_out pulses every 2 cycles, counters cycle 2,1,2,1…, running_out stays 1.
